// File: rtl/lamp_driver_pkg.sv
// lamp_driver_pkg: light codes, lamp bit positions, fault codes and helpers
package lamp_driver_pkg;
   localparam logic [1:0] CODE_FAIL   = 2'b00;
   localparam logic [1:0] CODE_GREEN  = 2'b01;
   localparam logic [1:0] CODE_YELLOW = 2'b10;
   localparam logic [1:0] CODE_RED    = 2'b11;
   localparam int LAMP_R = 2;
   localparam int LAMP_Y = 1;
   localparam int LAMP_G = 0;
   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_CONFLICT = 2'b01;
   localparam logic [1:0] FC_SKIP     = 2'b10;
   typedef enum logic [1:0] {NORMAL, FLASH, FAULT} state_t;
   function automatic logic [2:0] lamp_of(input logic [1:0] code);
      lamp_of = '0;
      lamp_of[LAMP_R] = code == CODE_RED;
      lamp_of[LAMP_Y] = code == CODE_YELLOW;
      lamp_of[LAMP_G] = code == CODE_GREEN;
   endfunction
   function automatic logic is_go(input logic [1:0] code);
      is_go = code == CODE_GREEN || code == CODE_YELLOW;
   endfunction
endpackage

// File: rtl/flash_timer.sv
// flash_timer: half-period counter with ON/OFF phase; on_next is the phase the next edge will hold
module flash_timer #(
   parameter int HALF = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic restart,
   input  logic en,
   output logic on_next
);
   logic [7:0] count;
   logic [7:0] count_next;
   logic       phase;
   logic       wrap;
   always_comb begin
      wrap       = en && count == 8'(HALF - 1);
      count_next = restart || wrap ? '0 : en ? count + 8'd1 : count;
      on_next    = restart ? 1'b1 : wrap ? ~phase : phase;
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count <= '0;
         phase <= 1'b1;
      end else begin
         count <= count_next;
         phase <= on_next;
      end
   end
endmodule

// File: rtl/lamp_driver.sv
// lamp_driver: decodes three light codes to lamps, watching for conflicts and skipped yellows;
// falls back to a red flash on FAIL codes and latches a fault until reset.
module lamp_driver
   import lamp_driver_pkg::*;
#(
   parameter int FLASH_HALF = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] L1,
   input  logic [1:0] L2,
   input  logic [1:0] L3,
   output logic [2:0] Lamp1,
   output logic [2:0] Lamp2,
   output logic [2:0] Lamp3,
   output logic       Fault,
   output logic [1:0] FaultCode
);
   state_t     st, st_n;
   logic [1:0] p1, p2, p3;
   logic [1:0] code_n;
   logic [2:0] n1, n2, n3, flash;
   logic       conflict, skip, any_fail, all_red, on_next;
   flash_timer #(.HALF(FLASH_HALF)) u_timer (
      .Clock  (Clock),
      .Reset  (Reset),
      .restart(st == NORMAL),
      .en     (st != NORMAL),
      .on_next(on_next)
   );
   always_comb begin
      conflict = is_go(L1) && (is_go(L2) || is_go(L3));
      skip     = (L1 == CODE_RED && p1 == CODE_GREEN) || (L2 == CODE_RED && p2 == CODE_GREEN)
               || (L3 == CODE_RED && p3 == CODE_GREEN);
      any_fail = L1 == CODE_FAIL || L2 == CODE_FAIL || L3 == CODE_FAIL;
      all_red  = L1 == CODE_RED && L2 == CODE_RED && L3 == CODE_RED;
      flash    = {on_next, 2'b00};
      st_n     = st;
      code_n   = FaultCode;
      n1       = flash;
      n2       = flash;
      n3       = flash;
      case (st)
         NORMAL:
            if (conflict || skip) begin
               st_n   = FAULT;
               code_n = conflict ? FC_CONFLICT : FC_SKIP;
            end else if (any_fail) begin
               st_n = FLASH;
            end else begin
               n1 = lamp_of(L1);
               n2 = lamp_of(L2);
               n3 = lamp_of(L3);
            end
         FLASH:
            if (conflict) begin
               st_n   = FAULT;
               code_n = FC_CONFLICT;
            end else if (all_red) begin
               st_n = NORMAL;
               n1   = lamp_of(L1);
               n2   = lamp_of(L2);
               n3   = lamp_of(L3);
            end
         default: ;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         st        <= FLASH;
         Lamp1     <= 3'b100;
         Lamp2     <= 3'b100;
         Lamp3     <= 3'b100;
         Fault     <= 1'b0;
         FaultCode <= FC_NONE;
         p1        <= CODE_RED;
         p2        <= CODE_RED;
         p3        <= CODE_RED;
      end else begin
         st        <= st_n;
         Lamp1     <= n1;
         Lamp2     <= n2;
         Lamp3     <= n3;
         Fault     <= st_n == FAULT;
         FaultCode <= code_n;
         p1        <= L1;
         p2        <= L2;
         p3        <= L3;
      end
   end
endmodule

// File: tb/tb_lamp_driver.sv
// tb_lamp_driver: directed scenarios plus random codes checked against a behavioural model
module tb_lamp_driver;
   localparam int HALF = 4;
   localparam int NM = 0, FL = 1, FT = 2;
   logic       clk = 0;
   logic       rst;
   logic [1:0] l1, l2, l3;
   logic [2:0] lamp1, lamp2, lamp3;
   logic       fault;
   logic [1:0] fcode;
   int checks = 0, failures = 0;
   bit live = 0;
   int         m_mode, m_t;
   logic [1:0] m_prev[3];
   logic [2:0] m_lamp[3];
   logic       m_fault;
   logic [1:0] m_code;
   lamp_driver #(.FLASH_HALF(HALF)) dut (
      .Clock(clk), .Reset(rst), .L1(l1), .L2(l2), .L3(l3),
      .Lamp1(lamp1), .Lamp2(lamp2), .Lamp3(lamp3), .Fault(fault), .FaultCode(fcode)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", n, act, exp, $time);
      end
   endtask
   function automatic logic [2:0] lamp_for(input logic [1:0] c);
      return c == 2'd1 ? 3'b001 : c == 2'd2 ? 3'b010 : c == 2'd3 ? 3'b100 : 3'b000;
   endfunction
   function automatic bit go(input logic [1:0] c);
      return c == 2'd1 || c == 2'd2;
   endfunction
   // t counts edges since entering flash/fault; the red lamp is lit in even half-periods
   task automatic model(input logic r, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      logic [1:0] cd[3];
      bit conf, skip, fail, allred;
      cd = '{a, b, c};
      if (r) begin
         m_mode = FL; m_t = 0; m_fault = 0; m_code = 0;
         for (int i = 0; i < 3; i++) begin m_lamp[i] = 3'b100; m_prev[i] = 2'd3; end
         return;
      end
      conf = go(a) && (go(b) || go(c));
      skip = 0; fail = 0; allred = 1;
      for (int i = 0; i < 3; i++) begin
         skip |= cd[i] == 2'd3 && m_prev[i] == 2'd1;
         fail |= cd[i] == 2'd0;
         allred &= cd[i] == 2'd3;
      end
      if (m_mode == NM) begin
         if (conf || skip) begin m_mode = FT; m_t = 0; m_fault = 1; m_code = conf ? 2'd1 : 2'd2; end
         else if (fail) begin m_mode = FL; m_t = 0; end
      end else if (m_mode == FL) begin
         m_t++;
         if (conf) begin m_mode = FT; m_fault = 1; m_code = 2'd1; end
         else if (allred) m_mode = NM;
      end else m_t++;
      for (int i = 0; i < 3; i++)
         m_lamp[i] = m_mode == NM ? lamp_for(cd[i]) : ((m_t / HALF) % 2 == 0 ? 3'b100 : 3'b000);
      m_prev = cd;
   endtask
   task automatic step(input logic r, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      rst = r; l1 = a; l2 = b; l3 = c;
      @(posedge clk);
      model(r, a, b, c);
      live = 1;
      #1;
   endtask
   always @(negedge clk) if (live) begin
      chk("lamp1", {5'd0, lamp1}, {5'd0, m_lamp[0]});
      chk("lamp2", {5'd0, lamp2}, {5'd0, m_lamp[1]});
      chk("lamp3", {5'd0, lamp3}, {5'd0, m_lamp[2]});
      chk("fault", {7'd0, fault}, {7'd0, m_fault});
      chk("fcode", {6'd0, fcode}, {6'd0, m_code});
   end
   initial begin
      logic [1:0] cur[3];
      rst = 1; l1 = 3; l2 = 3; l3 = 3;
      step(1, 3, 3, 3);
      chk("rst_lamp", {5'd0, lamp1}, 8'h4);
      chk("rst_fault", {7'd0, fault}, 8'h0);
      chk("rst_code", {6'd0, fcode}, 8'h0);
      step(0, 3, 3, 3);
      chk("allred_lamp3", {5'd0, lamp3}, 8'h4);
      step(0, 1, 3, 3); chk("seq_g", {5'd0, lamp1}, 8'h1);
      step(0, 2, 3, 3); chk("seq_y", {5'd0, lamp1}, 8'h2);
      step(0, 3, 3, 3); chk("seq_r", {5'd0, lamp1}, 8'h4);
      chk("seq_nofault", {7'd0, fault}, 8'h0);
      step(0, 1, 3, 3);
      step(0, 3, 3, 3);
      chk("skip_fault", {7'd0, fault}, 8'h1);
      chk("skip_code", {6'd0, fcode}, 8'h2);
      for (int k = 1; k <= 13; k++) begin
         step(0, k == 2 ? 2'd1 : 2'd3, 3, 3);
         chk("skip_flash", {5'd0, lamp2}, ((k / 4) % 2 == 0) ? 8'h4 : 8'h0);
         chk("skip_hold", {6'd0, fcode}, 8'h2);
      end
      step(1, 1, 1, 1);
      chk("rst_in_fault_lamp", {5'd0, lamp1}, 8'h4);
      chk("rst_in_fault_flt", {7'd0, fault}, 8'h0);
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 3, 3);
         chk("rst_restart", {5'd0, lamp1}, k == 4 ? 8'h0 : 8'h4);
      end
      step(0, 3, 3, 3);
      step(0, 1, 1, 3);
      chk("conf_code", {6'd0, fcode}, 8'h1);
      chk("conf_lamp1", {5'd0, lamp1}, 8'h4);
      for (int k = 0; k < 3; k++) begin
         step(0, 3, 3, 3);
         chk("conf_hold", {7'd0, fault}, 8'h1);
      end
      step(1, 3, 3, 3);
      step(0, 3, 3, 3);
      for (int k = 0; k < 10; k++) begin
         step(0, 3, 3, 0);
         chk("fail_pat", {5'd0, lamp1}, (k < 4 || k >= 8) ? 8'h4 : 8'h0);
      end
      step(0, 1, 3, 3); chk("mixed_stay", {5'd0, lamp1}, 8'h4);
      step(0, 3, 3, 3); chk("back_normal", {5'd0, lamp1}, 8'h4);
      step(0, 1, 3, 3); chk("normal_green", {5'd0, lamp1}, 8'h1);
      step(0, 2, 3, 3);
      cur = '{2'd3, 2'd3, 2'd3};
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 3) == 0) begin
               int v;
               v = $urandom_range(0, 7);
               cur[i] = v < 4 ? 2'd3 : 2'(v);
            end
         step($urandom_range(0, 39) == 0, cur[0], cur[1], cur[2]);
      end
      @(negedge clk);
      live = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
